// File: rtl/systolic_array_pkg.sv
// Shared types for the systolic array: IEEE-754 single-precision word bits and
// the partial-sum writeback FSM state encoding.
package systolic_array_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/psum_writeback.sv
// Snapshots the finished N x N partial-sum matrix and streams it to the
// scratchpad as N beats of N words, row- or column-major, under ready/valid.
//
// state | meaning
// IDLE  | waiting for start; matrix, base address and layout captured on start
// SEND  | presenting beat k; advances on wr_ready
// DONE  | one-cycle completion pulse, then back to IDLE
module psum_writeback
  import systolic_array_pkg::*;
#(
  parameter int N      = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              col_major,
  input  logic [ADDR_W-1:0] out_addr,
  input  word_t             psum_in [N][N],
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output word_t             wr_data [N],
  output logic              busy,
  output logic              done
);

  localparam int K_W = (N > 1) ? $clog2(N) : 1;

  state_t            state_q, state_d;
  logic [K_W-1:0]    k_q;
  logic [ADDR_W-1:0] base_q;
  logic              col_q;
  word_t             buf_q [N][N];
  logic              last_beat;
  logic              capture;
  logic              accept;

  assign last_beat = (k_q == K_W'(N - 1));
  assign capture   = (state_q == IDLE) && start;
  assign accept    = (state_q == SEND) && wr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Handshake outputs decode only the state register, never wr_ready/start.
  always_comb begin
    state_d  = state_q;
    wr_valid = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = SEND;
      end
      SEND: begin
        wr_valid = 1'b1;
        if (wr_ready && last_beat) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q    <= '0;
      base_q <= '0;
      col_q  <= 1'b0;
      buf_q  <= '{default: '0};
    end else if (capture) begin
      k_q    <= '0;
      base_q <= out_addr;
      col_q  <= col_major;
      buf_q  <= psum_in;
    end else if (accept && !last_beat) begin
      k_q <= k_q + 1'b1;
    end
  end

  assign wr_addr = base_q + ADDR_W'(k_q) * ADDR_W'(N);

  // Lane mux: row k of the snapshot, or column k when column-major.
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign wr_data[i] = col_q ? buf_q[i][k_q] : buf_q[k_q][i];
  end

endmodule

// File: tb/tb_psum_writeback.sv
// Randomized and directed bench for psum_writeback against a matrix-level
// reference: beat b carries row b (or column b) of the matrix seen at start.
module tb_psum_writeback;
  import systolic_array_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          col_major;
  logic [AW-1:0] out_addr;
  word_t         psum_in [N][N];
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  word_t         wr_data [N];
  logic          busy;
  logic          done;

  word_t mat  [N][N];
  word_t snap [N][N];

  int vectors     = 0;
  int miscompares = 0;

  logic [AW-1:0] obs_addr [64];
  word_t         obs_data [64][N];
  bit            obs_acc  [64];
  int            obs_n;
  int            done_cyc [8];
  int            done_n;
  bit            busy_at  [64];

  psum_writeback #(.N(N), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .col_major(col_major),
    .out_addr (out_addr),
    .psum_in  (psum_in),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Small positive integer to single-precision bits.
  function automatic word_t f32(input int v);
    int          e;
    int unsigned m;
    if (v == 0) return 32'h0;
    e = 0;
    while ((v >> (e + 1)) != 0) e++;
    m = (v - (1 << e)) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  function automatic word_t exp_lane(input bit col, input int b, input int i);
    return col ? snap[i][b] : snap[b][i];
  endfunction

  task automatic fill_random();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) mat[r][c] = $urandom;
  endtask

  task automatic fill_index();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) mat[r][c] = f32(r * 4 + c + 1);
  endtask

  // Drives one start and records every valid cycle for ncyc cycles after the start edge.
  task automatic run_xfer(input logic [AW-1:0] base, input bit col, input int stall_beat,
                          input int stall_len, input bit poke, input bit hold, input int ncyc);
    int acc, used;
    obs_n = 0; done_n = 0; acc = 0; used = 0;
    psum_in = mat;
    snap    = mat;
    @(negedge clk);
    out_addr = base; col_major = col; start = 1'b1; wr_ready = 1'b1;
    @(posedge clk); #1;
    if (!hold) begin
      start     = 1'b0;
      out_addr  = $urandom;
      col_major = ~col;
    end
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(negedge clk);
      if (poke && cyc == 2) begin
        psum_in = '{default: '0};
        start   = 1'b1;
      end else if (poke && cyc == 3) begin
        start = 1'b0;
      end
      wr_ready = !(acc == stall_beat && used < stall_len);
      if (!wr_ready) used++;
      busy_at[cyc] = busy;
      if (done && done_n < 8) begin
        done_cyc[done_n] = cyc;
        done_n++;
      end
      if (wr_valid && obs_n < 64) begin
        obs_addr[obs_n] = wr_addr;
        for (int i = 0; i < N; i++) obs_data[obs_n][i] = wr_data[i];
        obs_acc[obs_n] = wr_ready;
        obs_n++;
        if (wr_ready) acc++;
      end
    end
    start    = 1'b0;
    wr_ready = 1'b1;
    for (int t = 0; t < 20 && busy; t++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; col_major = 1'b1; wr_ready = 1'b1; out_addr = 32'hDEAD0000;
    fill_random();
    psum_in = mat;
    repeat (2) @(negedge clk);
    vectors++;
    if (wr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got valid=%b busy=%b done=%b want 0 0 0", wr_valid, busy, done);
    end
    vectors++;
    if (wr_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_addr got %h want 00000000", wr_addr);
    end
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (wr_data[i] !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_data lane%0d got %h want 00000000", i, wr_data[i]);
      end
    end
    rst = 1'b0;
  endtask

  // Row-major, column-major and address-wrap cases on the indexed matrix.
  task automatic test_layouts();
    logic [AW-1:0] bases [3] = '{32'h100, 32'h100, 32'hFFFF_FFFC};
    bit            cols  [3] = '{1'b0, 1'b1, 1'b0};
    int b;
    for (int t = 0; t < 3; t++) begin
      fill_index();
      run_xfer(bases[t], cols[t], 99, 0, 1'b0, 1'b0, 10);
      b = 0;
      for (int j = 0; j < obs_n; j++) begin
        vectors++;
        if (obs_addr[j] !== bases[t] + 32'(b * N)) begin
          miscompares++;
          $display("FAIL layout%0d_addr beat%0d got %h want %h", t, b, obs_addr[j], bases[t] + 32'(b * N));
        end
        for (int i = 0; i < N; i++) begin
          vectors++;
          if (obs_data[j][i] !== exp_lane(cols[t], b, i)) begin
            miscompares++;
            $display("FAIL layout%0d_data beat%0d lane%0d got %h want %h", t, b, i, obs_data[j][i], exp_lane(cols[t], b, i));
          end
        end
        if (obs_acc[j]) b++;
      end
      vectors++;
      if (obs_n !== N || b !== N) begin
        miscompares++;
        $display("FAIL layout%0d_beats got %0d valid/%0d accepted want %0d", t, obs_n, b, N);
      end
      vectors++;
      if (done_n !== 1 || done_cyc[0] !== N + 1) begin
        miscompares++;
        $display("FAIL layout%0d_done got %0d pulses first at %0d want 1 at %0d", t, done_n, done_cyc[0], N + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    int b;
    fill_index();
    run_xfer(32'h100, 1'b0, 2, 3, 1'b0, 1'b0, 12);
    b = 0;
    for (int j = 0; j < obs_n; j++) begin
      vectors++;
      if (obs_addr[j] !== 32'h100 + 32'(b * N)) begin
        miscompares++;
        $display("FAIL bp_addr obs%0d got %h want %h", j, obs_addr[j], 32'h100 + 32'(b * N));
      end
      for (int i = 0; i < N; i++) begin
        vectors++;
        if (obs_data[j][i] !== exp_lane(1'b0, b, i)) begin
          miscompares++;
          $display("FAIL bp_data obs%0d lane%0d got %h want %h", j, i, obs_data[j][i], exp_lane(1'b0, b, i));
        end
      end
      if (obs_acc[j]) b++;
    end
    vectors++;
    if (obs_n !== N + 3 || b !== N) begin
      miscompares++;
      $display("FAIL bp_beats got %0d valid/%0d accepted want %0d/%0d", obs_n, b, N + 3, N);
    end
    vectors++;
    if (done_n !== 1 || done_cyc[0] !== N + 4) begin
      miscompares++;
      $display("FAIL bp_done got %0d pulses first at %0d want 1 at %0d", done_n, done_cyc[0], N + 4);
    end
  endtask

  task automatic test_snapshot();
    int b;
    fill_random();
    run_xfer(32'h2000, 1'b1, 99, 0, 1'b1, 1'b0, 12);
    b = 0;
    for (int j = 0; j < obs_n; j++) begin
      for (int i = 0; i < N; i++) begin
        vectors++;
        if (obs_data[j][i] !== exp_lane(1'b1, b, i)) begin
          miscompares++;
          $display("FAIL snap_data beat%0d lane%0d got %h want %h", b, i, obs_data[j][i], exp_lane(1'b1, b, i));
        end
      end
      if (obs_acc[j]) b++;
    end
    vectors++;
    if (obs_n !== N || done_n !== 1 || done_cyc[0] !== N + 1) begin
      miscompares++;
      $display("FAIL snap_count got %0d beats %0d done want %0d beats 1 done", obs_n, done_n, N);
    end
  endtask

  task automatic test_reset_mid();
    int seen, beats, dcyc;
    fill_random();
    psum_in = mat; snap = mat;
    @(negedge clk);
    out_addr = 32'h300; col_major = 1'b0; start = 1'b1; wr_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (wr_valid !== 1'b1 || wr_addr !== 32'h304) begin
      miscompares++;
      $display("FAIL rmid_pre got valid=%b addr=%h want 1 00000304", wr_valid, wr_addr);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (wr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || wr_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL rmid_drop got valid=%b busy=%b done=%b addr=%h want 0 0 0 0", wr_valid, busy, done, wr_addr);
    end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (wr_valid || done) seen++;
    end
    fill_random();
    psum_in = mat; snap = mat;
    rst = 1'b0; out_addr = 32'h500; col_major = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    beats = 0; dcyc = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        vectors++;
        if (wr_valid !== 1'b1 || wr_addr !== 32'h500 || wr_data[2] !== exp_lane(1'b1, 0, 2)) begin
          miscompares++;
          $display("FAIL rmid_restart got valid=%b addr=%h lane2=%h want 1 00000500 %h", wr_valid, wr_addr, wr_data[2], exp_lane(1'b1, 0, 2));
        end
      end
      if (wr_valid) beats++;
      if (done) begin
        seen = (dcyc != 0) ? seen + 1 : seen;
        dcyc = cyc;
      end
    end
    vectors++;
    if (seen !== 0 || beats !== N || dcyc !== N + 1) begin
      miscompares++;
      $display("FAIL rmid_after got stray=%0d beats=%0d done_at=%0d want 0 %0d %0d", seen, beats, dcyc, N, N + 1);
    end
  endtask

  task automatic test_held_start();
    fill_random();
    run_xfer(32'h40, 1'b0, 99, 0, 1'b0, 1'b1, 12);
    vectors++;
    if (done_n !== 2 || done_cyc[0] !== N + 1 || done_cyc[1] !== 2 * N + 3) begin
      miscompares++;
      $display("FAIL held_done got %0d pulses at %0d,%0d want 2 at %0d,%0d", done_n, done_cyc[0], done_cyc[1], N + 1, 2 * N + 3);
    end
    vectors++;
    if (busy_at[N + 2] !== 1'b0 || busy_at[N + 3] !== 1'b1) begin
      miscompares++;
      $display("FAIL held_idle got busy=%b,%b want 0,1", busy_at[N + 2], busy_at[N + 3]);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] base;
    bit col;
    int sb, sl, b, bad;
    for (int t = 0; t < 20; t++) begin
      fill_random();
      base = $urandom;
      col  = 1'($urandom_range(0, 1));
      sb   = $urandom_range(0, N - 1);
      sl   = $urandom_range(0, 3);
      run_xfer(base, col, sb, sl, 1'b0, 1'b0, 14);
      b = 0; bad = 0;
      for (int j = 0; j < obs_n; j++) begin
        if (obs_addr[j] !== base + 32'(b * N)) bad++;
        for (int i = 0; i < N; i++)
          if (obs_data[j][i] !== exp_lane(col, b, i)) bad++;
        if (obs_acc[j]) b++;
      end
      vectors++;
      if (bad !== 0 || b !== N || obs_n !== N + sl) begin
        miscompares++;
        $display("FAIL rand%0d got %0d bad words %0d/%0d beats want 0 %0d/%0d", t, bad, b, obs_n, N, N + sl);
      end
      vectors++;
      if (done_n !== 1 || done_cyc[0] !== N + 1 + sl) begin
        miscompares++;
        $display("FAIL rand%0d_done got %0d pulses at %0d want 1 at %0d", t, done_n, done_cyc[0], N + 1 + sl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_layouts();
    test_backpressure();
    test_snapshot();
    test_reset_mid();
    test_held_start();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
